sw_debounce: RTL and testbench

Synchronises and debounces the raw board slide switches before they reach the LED pattern logic, which samples the switch bus only once per 1 s tick and requires a clean, glitch-free, one-level-per-bit value. Each bit passes through a 2-flop synchroniser and a per-bit stability counter. Outputs are the debounced level bus plus single-cycle rise/fall pulses for downstream mode-change handling. Sits between the top-level `sw` pads and the LED counter stage, in the 100 MHz `clk` domain.

---
 rtl/led_pkg.sv | 34 +++
 rtl/sw_debounce_bit.sv | 137 +++++++++++++
 rtl/sw_debounce.sv | 55 +++++
 tb/tb_sw_debounce.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared constants and types for the LED pattern front end.
//               Holds the debounce FSM state encoding and the clock/timing
//               constants used to derive the default debounce window.
// Contents    : db_state_t              - per-bit debounce FSM state
//               CLK_HZ                  - system clock frequency
//               DEBOUNCE_MS             - debounce window in milliseconds
//               DEBOUNCE_CYCLES_DEFAULT - debounce window in clock cycles
//               CNT_SIZE_DEFAULT        - stability counter width
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    // Single-bit encoding: IDLE means the synchronised input agrees with the
    // debounced output; PEND means a candidate level change is being timed.
    typedef enum logic {
        DB_IDLE = 1'b0,
        DB_PEND = 1'b1
    } db_state_t;

    localparam int CLK_HZ      = 100_000_000;
    localparam int DEBOUNCE_MS = 10;

    // 10 ms at 100 MHz = 1_000_000 cycles. Dividing first keeps the
    // intermediate product inside 32-bit signed range.
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // 20 bits covers the default window (2^20 - 1 = 1_048_575).
    localparam int CNT_SIZE_DEFAULT = 20;

endpackage : led_pkg
`default_nettype wire

// File: rtl/sw_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_bit
// Description : Synchroniser, stability counter and two-state FSM for one
//               switch bit. A new level is accepted only after it has been
//               observed on the synchronised input for DEBOUNCE_CYCLES
//               consecutive cycles; any return to the current output level
//               restarts the window.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               din   - raw asynchronous switch level
//               dout  - debounced level (registered)
//               rise  - one-cycle pulse when dout goes 0->1 (registered)
//               fall  - one-cycle pulse when dout goes 1->0 (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce_bit
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_SIZE        = CNT_SIZE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    // The observation that fills the window is the one seen while the
    // counter holds DEBOUNCE_CYCLES-1, so acceptance happens on the
    // DEBOUNCE_CYCLES-th consecutive mismatch and the counter never has to
    // hold more than DEBOUNCE_CYCLES-1.
    localparam logic [CNT_SIZE-1:0] C_CNT_LAST = CNT_SIZE'(DEBOUNCE_CYCLES - 1);

    // With a one-cycle window the first mismatch seen in IDLE is accepted
    // immediately and PEND is never entered.
    localparam bit C_ACCEPT_FIRST = (DEBOUNCE_CYCLES == 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                sync1_q;
    logic                sync2_q;
    db_state_t           state_q;
    db_state_t           state_d;
    logic [CNT_SIZE-1:0] cnt_q;
    logic [CNT_SIZE-1:0] cnt_d;
    logic                dout_q;
    logic                dout_d;
    logic                rise_q;
    logic                rise_d;
    logic                fall_q;
    logic                fall_d;

    // Only sync2_q feeds the FSM; sync1_q may be metastable.
    logic mismatch;
    assign mismatch = (sync2_q != dout_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            DB_IDLE: begin
                cnt_d = '0;
                if (mismatch) begin
                    if (C_ACCEPT_FIRST) begin
                        dout_d = sync2_q;
                        rise_d = sync2_q;
                        fall_d = ~sync2_q;
                    end else begin
                        state_d = DB_PEND;
                        cnt_d   = CNT_SIZE'(1);
                    end
                end
            end

            DB_PEND: begin
                if (!mismatch) begin
                    // Bounced back to the current level: abandon the window.
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    dout_d  = sync2_q;
                    rise_d  = sync2_q;
                    fall_d  = ~sync2_q;
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_SIZE'(1);
                end
            end

            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule : sw_debounce_bit
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Synchronises and debounces the board slide switches before
//               they reach the LED pattern logic. Each bit is handled by an
//               independent sw_debounce_bit instance; the per-bit edge pulses
//               are OR-reduced into a single change indication.
// Ports       : clk        - 100 MHz system clock
//               rst_n      - asynchronous active-low reset
//               sw_in      - raw asynchronous switch levels from pads
//               sw_out     - debounced switch levels (registered)
//               sw_rise    - per-bit one-cycle 0->1 pulses (registered)
//               sw_fall    - per-bit one-cycle 1->0 pulses (registered)
//               sw_changed - high whenever any rise/fall pulse is high
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce
    import led_pkg::*;
#(
    parameter int SW_SIZE         = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_SIZE        = CNT_SIZE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SW_SIZE-1:0] sw_in,
    output logic [SW_SIZE-1:0] sw_out,
    output logic [SW_SIZE-1:0] sw_rise,
    output logic [SW_SIZE-1:0] sw_fall,
    output logic               sw_changed
);

    genvar gi;
    generate
        for (gi = 0; gi < SW_SIZE; gi++) begin : g_bit
            sw_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_SIZE        (CNT_SIZE)
            ) u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (sw_in[gi]),
                .dout  (sw_out[gi]),
                .rise  (sw_rise[gi]),
                .fall  (sw_fall[gi])
            );
        end
    endgenerate

    // Pulses are registered and one cycle wide, so this is glitch-free at
    // the flop outputs and also exactly one cycle wide per change event.
    assign sw_changed = |(sw_rise | sw_fall);

endmodule : sw_debounce
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_debounce
// Description : Directed self-checking bench for sw_debounce with a 4-cycle
//               debounce window. Inputs change on the falling edge; outputs
//               are sampled 1 ns after each rising edge. Edge k is the k-th
//               rising edge after an input change (or after reset release),
//               so a held change appears at edge DEBOUNCE_CYCLES+2 = 6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debounce;

    localparam int SW_SIZE         = 8;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_SIZE        = 20;
    localparam int EDGE_UPD        = DEBOUNCE_CYCLES + 2;

    logic               clk;
    logic               rst_n;
    logic [SW_SIZE-1:0] sw_in;
    logic [SW_SIZE-1:0] sw_out;
    logic [SW_SIZE-1:0] sw_rise;
    logic [SW_SIZE-1:0] sw_fall;
    logic               sw_changed;

    int n_cmp;
    int n_err;

    logic [SW_SIZE-1:0] exp_out;
    logic [SW_SIZE-1:0] exp_rise;
    logic [SW_SIZE-1:0] exp_fall;
    logic               exp_ch;

    sw_debounce #(
        .SW_SIZE         (SW_SIZE),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_SIZE        (CNT_SIZE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_in      (sw_in),
        .sw_out     (sw_out),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: drive a level and let it fully settle.
    task automatic settle(input logic [SW_SIZE-1:0] v);
        @(negedge clk);
        sw_in = v;
        repeat (EDGE_UPD + 4) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({sw_out, sw_rise, sw_fall, sw_changed} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_hold: out=%h rise=%h fall=%h ch=%b, want all 0",
                     sw_out, sw_rise, sw_fall, sw_changed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            exp_out  = (k >= EDGE_UPD) ? 8'hFF : 8'h00;
            exp_rise = (k == EDGE_UPD) ? 8'hFF : 8'h00;
            exp_fall = 8'h00;
            exp_ch   = (k == EDGE_UPD);
            n_cmp++;
            if ({sw_out, sw_rise, sw_fall, sw_changed} !== {exp_out, exp_rise, exp_fall, exp_ch}) begin
                n_err++;
                $display("FAIL reset_release edge %0d: out=%h rise=%h fall=%h ch=%b, want out=%h rise=%h fall=%h ch=%b",
                         k, sw_out, sw_rise, sw_fall, sw_changed, exp_out, exp_rise, exp_fall, exp_ch);
            end
        end
    endtask

    task automatic test_clean_change();
        settle(8'h00);
        @(negedge clk);
        sw_in = 8'h02;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            exp_out  = (k >= EDGE_UPD) ? 8'h02 : 8'h00;
            exp_rise = (k == EDGE_UPD) ? 8'h02 : 8'h00;
            exp_fall = 8'h00;
            exp_ch   = (k == EDGE_UPD);
            n_cmp++;
            if ({sw_out, sw_rise, sw_fall, sw_changed} !== {exp_out, exp_rise, exp_fall, exp_ch}) begin
                n_err++;
                $display("FAIL clean_change edge %0d: out=%h rise=%h fall=%h ch=%b, want out=%h rise=%h fall=%h ch=%b",
                         k, sw_out, sw_rise, sw_fall, sw_changed, exp_out, exp_rise, exp_fall, exp_ch);
            end
        end
    endtask

    task automatic test_bounce();
        settle(8'h00);
        // 1,0,1,0 in 2-cycle runs: never 4 consecutive synced mismatches.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sw_in = (i % 2 == 0) ? 8'h04 : 8'h00;
            for (int j = 0; j < 2; j++) begin
                @(posedge clk);
                #1;
                n_cmp++;
                if ({sw_out, sw_rise, sw_fall, sw_changed} !== 25'd0) begin
                    n_err++;
                    $display("FAIL bounce_run %0d/%0d: out=%h rise=%h fall=%h ch=%b, want all 0",
                             i, j, sw_out, sw_rise, sw_fall, sw_changed);
                end
            end
        end
        @(negedge clk);
        sw_in = 8'h04;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            exp_out  = (k >= EDGE_UPD) ? 8'h04 : 8'h00;
            exp_rise = (k == EDGE_UPD) ? 8'h04 : 8'h00;
            exp_fall = 8'h00;
            exp_ch   = (k == EDGE_UPD);
            n_cmp++;
            if ({sw_out, sw_rise, sw_fall, sw_changed} !== {exp_out, exp_rise, exp_fall, exp_ch}) begin
                n_err++;
                $display("FAIL bounce_settle edge %0d: out=%h rise=%h fall=%h ch=%b, want out=%h rise=%h fall=%h ch=%b",
                         k, sw_out, sw_rise, sw_fall, sw_changed, exp_out, exp_rise, exp_fall, exp_ch);
            end
        end
    endtask

    task automatic test_short_glitch();
        settle(8'h00);
        @(negedge clk);
        sw_in = 8'h08;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({sw_out, sw_rise, sw_fall, sw_changed} !== 25'd0) begin
                n_err++;
                $display("FAIL short_glitch edge %0d: out=%h rise=%h fall=%h ch=%b, want all 0",
                         k, sw_out, sw_rise, sw_fall, sw_changed);
            end
            // Three cycles high, then back low.
            if (k == 3) begin
                @(negedge clk);
                sw_in = 8'h00;
            end
        end
    endtask

    task automatic test_simultaneous();
        settle(8'h01);
        #1;
        n_cmp++;
        if (sw_out !== 8'h01) begin
            n_err++;
            $display("FAIL simul_setup: out=%h, want 01", sw_out);
        end
        @(negedge clk);
        sw_in = 8'h08;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            exp_out  = (k >= EDGE_UPD) ? 8'h08 : 8'h01;
            exp_rise = (k == EDGE_UPD) ? 8'h08 : 8'h00;
            exp_fall = (k == EDGE_UPD) ? 8'h01 : 8'h00;
            exp_ch   = (k == EDGE_UPD);
            n_cmp++;
            if ({sw_out, sw_rise, sw_fall, sw_changed} !== {exp_out, exp_rise, exp_fall, exp_ch}) begin
                n_err++;
                $display("FAIL simultaneous edge %0d: out=%h rise=%h fall=%h ch=%b, want out=%h rise=%h fall=%h ch=%b",
                         k, sw_out, sw_rise, sw_fall, sw_changed, exp_out, exp_rise, exp_fall, exp_ch);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        settle(8'h00);
        @(negedge clk);
        sw_in = 8'h01;
        // Edges 3..5 are the three synced mismatch observations.
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({sw_out, sw_rise, sw_fall, sw_changed} !== 25'd0) begin
                n_err++;
                $display("FAIL midrst_count edge %0d: out=%h rise=%h fall=%h ch=%b, want all 0",
                         k, sw_out, sw_rise, sw_fall, sw_changed);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        sw_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({sw_out, sw_rise, sw_fall, sw_changed} !== 25'd0) begin
                n_err++;
                $display("FAIL midrst_after edge %0d: out=%h rise=%h fall=%h ch=%b, want all 0",
                         k, sw_out, sw_rise, sw_fall, sw_changed);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        sw_in = '0;

        test_reset();
        test_clean_change();
        test_bounce();
        test_short_glitch();
        test_simultaneous();
        test_reset_mid_count();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sw_debounce
`default_nettype wire
